hart_fetch_sched: RTL
=====================

// Module: hart_fetch_sched
// PURPOSE
//  Round-robin fetch scheduler for the multi-hart FMRT Mini Core. Tracks per-hart run state from
//  Hart Control Unit commands (start/kill/idle) and memory-block events. Each cycle it selects the
//  hart the IF stage fetches for, producing if_hart_id/if_en that travel down the IF/ID/EX registers.
//  Emits start redirects (hart PC load) and kill pulses (flush pipeline entries tagged with that hart).
// PARAMETERS
//  HART_NUM   4   number of harts, power of two, 2..8
//  HART_ID_W  2   hart id width = log2(HART_NUM)
//  PC_W       32  program counter width
// PORTS
//  clk         in   1          clock
//  reset       in   1          synchronous, active-high reset
//  stall       in   1          global pipeline stall; freezes the selection outputs
//  hstart      in   1          start hart set_hid at PC hs_pc
//  set_hid     in   HART_ID_W  hart to start
//  hs_pc       in   PC_W       start PC
//  hkill       in   1          kill hart hs_id (with pipeline flush)
//  hidle       in   1          park hart hs_id (no flush; in-flight instructions drain)
//  hs_id       in   HART_ID_W  target of hkill/hidle
//  blk_set     in   1          hart blk_hid blocked (e.g. cache miss)
//  blk_hid     in   HART_ID_W  hart to block
//  blk_clr     in   1          hart clr_hid unblocked
//  clr_hid     in   HART_ID_W  hart to unblock
//  if_en       out  1          fetch slot valid
//  if_hart_id  out  HART_ID_W  hart owning this fetch slot
//  start_vld   out  1          1-cycle pulse: IF loads start_pc into hart start_hid's PC
//  start_hid   out  HART_ID_W
//  start_pc    out  PC_W
//  kill_vld    out  1          1-cycle pulse: flush every stage whose hart id == kill_hid
//  kill_hid    out  HART_ID_W
//  active_mask out  HART_NUM   bit i = 1 when hart i is RUN or BLOCKED
// BEHAVIOUR
//  Reset: all outputs registered. hart0=RUN, others IDLE; active_mask=1; if_en=0; if_hart_id=0;
//   start_vld=kill_vld=0; start_hid=kill_hid=0; start_pc=0. First selection on the edge after reset drops.
//  Per-hart state IDLE/RUN/BLOCKED, updated every edge regardless of stall:
//   IDLE->RUN on hstart; RUN->BLOCKED on blk_set; BLOCKED->RUN on blk_clr;
//   RUN|BLOCKED->IDLE on hkill or hidle. Commands not matching a listed transition are ignored
//   (no pulse): hstart on non-IDLE, blk_set on non-RUN, blk_clr on non-BLOCKED, hkill/hidle on IDLE.
//  Same-hart priority: hkill > hidle > blk_set > blk_clr > hstart. Different targets act independently.
//  hkill accepted at edge N -> kill_vld=1, kill_hid=hs_id for exactly cycle N+1.
//  hstart accepted at edge N -> start_vld=1, start_hid/start_pc valid for exactly cycle N+1.
//   The hart is not eligible at edge N; earliest fetch is if_hart_id=set_hid from N+1 to N+2.
//  Selection (stall=0): runnable = RUN and not targeted by hkill/hidle/blk_set this cycle.
//   Pick the first runnable hart strictly after if_hart_id, wrapping modulo HART_NUM; the current
//   hart is last in order (a sole runnable hart is picked every cycle). None runnable: if_en=0,
//   if_hart_id holds.
//  stall=1: if_en/if_hart_id hold. Exception: if the held hart is killed, idled or blocked,
//   if_en=0 at the next edge.
//  active_mask reflects state after the edge. reset mid-operation: reset values next edge, pulses dropped.
// TESTING
//  1 reset, no cmds -> if_en=1, if_hart_id=0 every cycle; active_mask=4'b0001.
//  2 hstart set_hid=2 hs_pc=0x100 -> next cycle start_vld=1,start_hid=2,start_pc=0x100;
//    then if_hart_id alternates 0,2,0,2.
//  3 harts 0..3 RUN, blk_set blk_hid=1 -> sequence 0,2,3,0; blk_clr clr_hid=1 -> 1 resumes in order.
//  4 hkill hs_id=0 with only hart0 RUN -> kill_vld=1,kill_hid=0 one cycle; if_en=0; active_mask=0.
//  5 stall=1 with hart3 held, hkill hs_id=3 -> kill pulse, if_en=0 next edge, id held until stall=0.
//  6 hkill and hstart same hart/cycle -> kill wins, no start_vld; hstart on RUN hart -> no pulse.

Source files
------------

// File: rtl/hart_fetch_sched.sv
// hart_fetch_sched: round-robin fetch scheduler for the multi-hart FMRT Mini Core.
// Tracks per-hart run state from hart-control commands and memory-block events,
// picks the hart the IF stage fetches for each cycle, and emits start redirects
// and kill pulses toward the pipeline.
//
// Output signalling: there is no back-pressure on any output. start_vld and
// kill_vld are single-cycle strobes; their companion id/pc fields are meaningful
// only while the strobe is high and hold their last loaded value otherwise.
// if_en qualifies if_hart_id: a fetch slot exists only in cycles where if_en=1.
module hart_fetch_sched #(
   parameter int HART_NUM  = 4,
   parameter int HART_ID_W = 2,
   parameter int PC_W      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 hstart,
   input  logic [HART_ID_W-1:0] set_hid,
   input  logic [PC_W-1:0]      hs_pc,
   input  logic                 hkill,
   input  logic                 hidle,
   input  logic [HART_ID_W-1:0] hs_id,
   input  logic                 blk_set,
   input  logic [HART_ID_W-1:0] blk_hid,
   input  logic                 blk_clr,
   input  logic [HART_ID_W-1:0] clr_hid,
   output logic                 if_en,
   output logic [HART_ID_W-1:0] if_hart_id,
   output logic                 start_vld,
   output logic [HART_ID_W-1:0] start_hid,
   output logic [PC_W-1:0]      start_pc,
   output logic                 kill_vld,
   output logic [HART_ID_W-1:0] kill_hid,
   output logic [HART_NUM-1:0]  active_mask
);

   typedef enum logic [1:0] {
      HS_IDLE    = 2'd0,
      HS_RUN     = 2'd1,
      HS_BLOCKED = 2'd2
   } hart_state_e;

   // Per-hart state; hart_state_q is the observation point for checkers.
   hart_state_e hart_state_q [HART_NUM];
   hart_state_e hart_state_d [HART_NUM];

   // One-hot command decode per hart.
   logic [HART_NUM-1:0] kill_hit;
   logic [HART_NUM-1:0] idle_hit;
   logic [HART_NUM-1:0] bset_hit;
   logic [HART_NUM-1:0] bclr_hit;
   logic [HART_NUM-1:0] start_hit;

   // Accepted (state-changing) start/kill per hart, and harts eligible to fetch.
   logic [HART_NUM-1:0] start_acc;
   logic [HART_NUM-1:0] kill_acc;
   logic [HART_NUM-1:0] runnable;
   logic [HART_NUM-1:0] active_d;

   // Selection next values.
   logic                 sel_found;
   logic [HART_ID_W-1:0] sel_id;
   logic [HART_ID_W-1:0] sel_cand;
   logic                 if_en_d;
   logic [HART_ID_W-1:0] if_hart_id_d;

   // Decode which harts each command targets this cycle.
   always_comb begin
      kill_hit  = '0;
      idle_hit  = '0;
      bset_hit  = '0;
      bclr_hit  = '0;
      start_hit = '0;
      for (int i = 0; i < HART_NUM; i++) begin
         kill_hit[i]  = hkill   && (hs_id   == HART_ID_W'(i));
         idle_hit[i]  = hidle   && (hs_id   == HART_ID_W'(i));
         bset_hit[i]  = blk_set && (blk_hid == HART_ID_W'(i));
         bclr_hit[i]  = blk_clr && (clr_hid == HART_ID_W'(i));
         start_hit[i] = hstart  && (set_hid == HART_ID_W'(i));
      end
   end

   // Per-hart next state: the highest-priority command aimed at a hart is the
   // only one considered; if it does not fit the current state it is dropped.
   always_comb begin
      start_acc = '0;
      kill_acc  = '0;
      runnable  = '0;
      active_d  = '0;
      for (int i = 0; i < HART_NUM; i++) begin
         hart_state_d[i] = hart_state_q[i];
         case (hart_state_q[i])
            HS_IDLE: begin
               if (!kill_hit[i] && !idle_hit[i] && !bset_hit[i] && !bclr_hit[i] && start_hit[i]) begin
                  hart_state_d[i] = HS_RUN;
                  start_acc[i]    = 1'b1;
               end
            end
            HS_RUN: begin
               if (kill_hit[i]) begin
                  hart_state_d[i] = HS_IDLE;
                  kill_acc[i]     = 1'b1;
               end else if (idle_hit[i]) begin
                  hart_state_d[i] = HS_IDLE;
               end else if (bset_hit[i]) begin
                  hart_state_d[i] = HS_BLOCKED;
               end
            end
            HS_BLOCKED: begin
               if (kill_hit[i]) begin
                  hart_state_d[i] = HS_IDLE;
                  kill_acc[i]     = 1'b1;
               end else if (idle_hit[i]) begin
                  hart_state_d[i] = HS_IDLE;
               end else if (!bset_hit[i] && bclr_hit[i]) begin
                  hart_state_d[i] = HS_RUN;
               end
            end
            default: begin
               hart_state_d[i] = HS_IDLE;
            end
         endcase
         // A hart leaving RUN this cycle must not receive the slot.
         runnable[i] = (hart_state_q[i] == HS_RUN) && !kill_hit[i] && !idle_hit[i] && !bset_hit[i];
         active_d[i] = (hart_state_d[i] != HS_IDLE);
      end
   end

   // Round-robin pick: first runnable hart after the current one, current last.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = if_hart_id;
      sel_cand  = if_hart_id;
      for (int k = 1; k <= HART_NUM; k++) begin
         sel_cand = if_hart_id + k[HART_ID_W-1:0];
         if (!sel_found && runnable[sel_cand]) begin
            sel_found = 1'b1;
            sel_id    = sel_cand;
         end
      end
      if (stall) begin
         // Frozen slot, but a hart that just lost RUN gives up its slot.
         if_en_d      = if_en && runnable[if_hart_id];
         if_hart_id_d = if_hart_id;
      end else begin
         if_en_d      = sel_found;
         if_hart_id_d = sel_id;
      end
   end

   // Hart state register; hart 0 comes out of reset running.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < HART_NUM; i++) begin
            hart_state_q[i] <= (i == 0) ? HS_RUN : HS_IDLE;
         end
      end else begin
         for (int i = 0; i < HART_NUM; i++) begin
            hart_state_q[i] <= hart_state_d[i];
         end
      end
   end

   // Registered fetch selection and active mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_en       <= 1'b0;
         if_hart_id  <= '0;
         active_mask <= HART_NUM'(1);
      end else begin
         if_en       <= if_en_d;
         if_hart_id  <= if_hart_id_d;
         active_mask <= active_d;
      end
   end

   // Start and kill strobes with their payloads.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_vld <= 1'b0;
         start_hid <= '0;
         start_pc  <= '0;
         kill_vld  <= 1'b0;
         kill_hid  <= '0;
      end else begin
         start_vld <= |start_acc;
         kill_vld  <= |kill_acc;
         if (|start_acc) begin
            start_hid <= set_hid;
            start_pc  <= hs_pc;
         end
         if (|kill_acc) begin
            kill_hid <= hs_id;
         end
      end
   end

endmodule
